fetch_mem_ctrl: RTL and testbench
=================================

FETCH_MEM_CTRL -- requirements
Module: fetch_mem_ctrl

Interface
REQ-001 Parameter: WAIT, default 1, SRAM read cycles per access (legal range 1..7).
REQ-002 Port: CLK  in  1  system clock; all state updates on rising edge.
REQ-003 Port: RST  in  1  reset, asynchronous, active-low.
REQ-004 Port: pc_i  in  16  instruction address from the fetch stage.
REQ-005 Port: instr_o  out  16  instruction word for pc_i; 16'h0800 (NOP) when not valid.
REQ-006 Port: stall_pc_o  out  1  high means the fetch stage holds pc this cycle.
REQ-007 Port: mem_rd_i  in  1  data-read request, held until accepted.
REQ-008 Port: mem_wr_i  in  1  data-write request, held until accepted.
REQ-009 Port: mem_addr_i  in  16  data address.
REQ-010 Port: mem_wdata_i  in  16  write data.
REQ-011 Port: mem_rdata_o  out  16  registered read data, stable until the next data read completes.
REQ-012 Port: mem_busy_o  out  1  high while a data request is present and not completing this cycle.
REQ-013 Port: ram_addr_o  out  16  SRAM address.
REQ-014 Port: ram_data_i  in  16  SRAM read data bus.
REQ-015 Port: ram_data_o  out  16  SRAM write data bus.
REQ-016 Port: ram_data_oe_o  out  1  drive enable for ram_data_o (board tristate).
REQ-017 Port: ram_ce_n_o, ram_oe_n_o, ram_we_n_o  out  1 each  SRAM strobes, active-low.

Function
REQ-018 The FSM SHALL have the states FETCH, DRD (data read), WR_SETUP, WR_PULSE and WR_HOLD, plus a 3-bit cycle counter cnt.
REQ-019 In FETCH the block SHALL drive ram_addr_o=pc_i, ce_n=0, oe_n=0, we_n=1 and ram_data_oe_o=0.
REQ-020 In FETCH, cnt SHALL increment each cycle, and the fetch SHALL complete on the cycle where cnt==WAIT-1; cnt then returns to 0.
REQ-021 On the fetch completion cycle: instr_o=ram_data_i (combinational), stall_pc_o=0.
REQ-022 On every other cycle: instr_o=16'h0800, stall_pc_o=1.
REQ-023 With WAIT=1 and no data requests, one instruction SHALL complete per cycle and stall_pc_o SHALL stay 0.
REQ-024 A data request seen in FETCH with cnt==0 SHALL preempt the fetch; the FSM goes to DRD (read) or WR_SETUP (write) on the next edge.
REQ-025 A fetch already in progress (cnt>0) SHALL finish before a pending data request is taken.
REQ-026 If mem_rd_i and mem_wr_i are both high, the write SHALL be performed and the read ignored.
REQ-027 DRD SHALL drive ram_addr_o=mem_addr_i, ce_n=0, oe_n=0, and last WAIT cycles.
REQ-028 On the last DRD cycle, mem_rdata_o SHALL latch ram_data_i at the edge, mem_busy_o=0 that cycle, and the FSM returns to FETCH with cnt=0.
REQ-029 WR_SETUP, WR_PULSE and WR_HOLD SHALL each last one cycle, with ram_addr_o=mem_addr_i, ram_data_o=mem_wdata_i, ram_data_oe_o=1, ce_n=0 and oe_n=1.
REQ-030 ram_we_n_o SHALL be 0 only in WR_PULSE.
REQ-031 mem_busy_o SHALL be 0 in WR_HOLD, and the FSM then returns to FETCH.
REQ-032 stall_pc_o SHALL be 1 and instr_o=16'h0800 throughout every data-access state.
REQ-033 mem_busy_o = (mem_rd_i|mem_wr_i) AND NOT(data completion this cycle).
REQ-034 mem_busy_o SHALL be 1 while a request waits in FETCH.
REQ-035 After a data access, the interrupted fetch SHALL restart from cnt=0 using the current pc_i.
REQ-036 A request deasserted before it is accepted SHALL be dropped without any SRAM access.
REQ-037 ram_data_oe_o SHALL never be 1 in any cycle where ram_oe_n_o=0.

Reset
REQ-038 While RST=0, the block SHALL hold: state=FETCH, cnt=0, mem_rdata_o=16'h0000, ce_n=oe_n=we_n=1, ram_data_oe_o=0, stall_pc_o=1, instr_o=16'h0800, mem_busy_o=0.
REQ-039 RST asserted mid-write SHALL force ram_we_n_o=1 and ram_data_oe_o=0 immediately (asynchronously); the aborted access SHALL not be retried.
REQ-040 After RST rises, the first fetch SHALL start on the next rising edge.

Verification
REQ-041 Scenario 1: WAIT=1, pc_i stepping 0,1,2, SRAM model holding 0x4801,0x4802,0x4803 -> instr_o=0x4801,0x4802,0x4803 on consecutive cycles; stall_pc_o=0 throughout.
REQ-042 Scenario 2: WAIT=2, pc_i=0x0010, ram[0x0010]=0x1234 -> stall_pc_o=1,0 and instr_o=0x0800,0x1234, repeating.
REQ-043 Scenario 3: WAIT=1, mem_rd_i=1 with mem_addr_i=0x8000, ram=0xBEEF -> mem_busy_o=1,0; mem_rdata_o=0xBEEF after the DRD edge; stall_pc_o=1 for 2 cycles; fetch resumes at the same pc.
REQ-044 Scenario 4: mem_wr_i=1, addr=0x8001, wdata=0x00A5 -> we_n=1,0,1 over WR_SETUP/WR_PULSE/WR_HOLD; ram[0x8001]=0x00A5; mem_busy_o low only in WR_HOLD.
REQ-045 Scenario 5: mem_rd_i and mem_wr_i both high at addr 0x8002 -> write performed; mem_rdata_o unchanged.
REQ-046 Scenario 6: RST pulsed low during WR_PULSE -> we_n=1 and ram_data_oe_o=0 within the same cycle; after release the first access is a fetch of pc_i with no write completed.

Source files
------------

// File: rtl/fetch_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// fetch_mem_ctrl_if : fetch port, data port and SRAM bus of the memory controller
// Rev 1.0
// ============================================================================
interface fetch_mem_ctrl_if;
    logic [15:0] pc_i;
    logic [15:0] instr_o;
    logic        stall_pc_o;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [15:0] mem_addr_i;
    logic [15:0] mem_wdata_i;
    logic [15:0] mem_rdata_o;
    logic        mem_busy_o;
    logic [15:0] ram_addr_o;
    logic [15:0] ram_data_i;
    logic [15:0] ram_data_o;
    logic        ram_data_oe_o;
    logic        ram_ce_n_o;
    logic        ram_oe_n_o;
    logic        ram_we_n_o;

    // master is the controller, which owns the SRAM bus
    modport master (
        input  pc_i, mem_rd_i, mem_wr_i, mem_addr_i, mem_wdata_i, ram_data_i,
        output instr_o, stall_pc_o, mem_rdata_o, mem_busy_o,
        output ram_addr_o, ram_data_o, ram_data_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );

    modport slave (
        output pc_i, mem_rd_i, mem_wr_i, mem_addr_i, mem_wdata_i, ram_data_i,
        input  instr_o, stall_pc_o, mem_rdata_o, mem_busy_o,
        input  ram_addr_o, ram_data_o, ram_data_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_mem_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_mem_ctrl : shares one async SRAM between instruction fetch and data port
// Rev 1.0
// ============================================================================
module fetch_mem_ctrl #(
    parameter int WAIT = 1
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    fetch_mem_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DRD      = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4
    } state_t;

    localparam logic [2:0]  c_last_cnt = 3'(WAIT - 1);
    localparam logic [15:0] c_nop      = 16'h0800;

    state_t      r_state;
    state_t      w_nxt_state;
    logic [2:0]  r_cnt;
    logic [2:0]  w_nxt_cnt;
    logic        r_run;
    logic [15:0] r_rdata;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_data_oe;

    logic w_req;
    logic w_cnt_last;
    logic w_preempt;
    logic w_fetch_done;
    logic w_data_done;

    assign w_req        = bus.mem_rd_i | bus.mem_wr_i;
    assign w_cnt_last   = (r_cnt == c_last_cnt);
    // Data requests only win at the start of a fetch, never mid-fetch
    assign w_preempt    = r_run && (r_state == S_FETCH) && (r_cnt == 3'd0) && w_req;
    assign w_fetch_done = r_run && (r_state == S_FETCH) && w_cnt_last && !w_preempt;
    assign w_data_done  = ((r_state == S_DRD) && w_cnt_last) || (r_state == S_WR_HOLD);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_FETCH: begin
                if (!r_run) begin
                    w_nxt_cnt = 3'd0;
                end else if (w_preempt) begin
                    w_nxt_state = bus.mem_wr_i ? S_WR_SETUP : S_DRD;
                    w_nxt_cnt   = 3'd0;
                end else if (w_cnt_last) begin
                    w_nxt_cnt = 3'd0;
                end else begin
                    w_nxt_cnt = r_cnt + 3'd1;
                end
            end
            S_DRD: begin
                if (w_cnt_last) begin
                    w_nxt_state = S_FETCH;
                    w_nxt_cnt   = 3'd0;
                end else begin
                    w_nxt_cnt = r_cnt + 3'd1;
                end
            end
            S_WR_SETUP: begin
                w_nxt_state = S_WR_PULSE;
                w_nxt_cnt   = 3'd0;
            end
            S_WR_PULSE: begin
                w_nxt_state = S_WR_HOLD;
                w_nxt_cnt   = 3'd0;
            end
            S_WR_HOLD: begin
                w_nxt_state = S_FETCH;
                w_nxt_cnt   = 3'd0;
            end
            default: begin
                w_nxt_state = S_FETCH;
                w_nxt_cnt   = 3'd0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they are glitch-free flops
    // that the asynchronous reset can release the SRAM with instantly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_FETCH;
            r_cnt     <= 3'd0;
            r_run     <= 1'b0;
            r_rdata   <= 16'h0000;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_data_oe <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if ((r_state == S_DRD) && w_cnt_last) begin
                r_rdata <= bus.ram_data_i;
            end
            r_ce_n    <= 1'b0;
            r_oe_n    <= !((w_nxt_state == S_FETCH) || (w_nxt_state == S_DRD));
            r_we_n    <= (w_nxt_state != S_WR_PULSE);
            r_data_oe <= (w_nxt_state == S_WR_SETUP) || (w_nxt_state == S_WR_PULSE) ||
                         (w_nxt_state == S_WR_HOLD);
        end
    end

    assign bus.instr_o       = w_fetch_done ? bus.ram_data_i : c_nop;
    assign bus.stall_pc_o    = !w_fetch_done;
    assign bus.mem_busy_o    = r_run && w_req && !w_data_done;
    assign bus.mem_rdata_o   = r_rdata;
    assign bus.ram_addr_o    = (r_state == S_FETCH) ? bus.pc_i : bus.mem_addr_i;
    assign bus.ram_data_o    = bus.mem_wdata_i;
    assign bus.ram_data_oe_o = r_data_oe;
    assign bus.ram_ce_n_o    = r_ce_n;
    assign bus.ram_oe_n_o    = r_oe_n;
    assign bus.ram_we_n_o    = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_mem_ctrl : scoreboard bench for fetch_mem_ctrl with WAIT=1 and WAIT=2
// Rev 1.0
// ============================================================================
module tb_fetch_mem_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    fetch_mem_ctrl_if bus1 ();
    fetch_mem_ctrl_if bus2 ();

    fetch_mem_ctrl #(.WAIT(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
    fetch_mem_ctrl #(.WAIT(2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    always #5 CLK = ~CLK;

    logic [15:0] ram1 [0:65535];
    logic [15:0] ram2 [0:65535];

    assign bus1.ram_data_i = (!bus1.ram_ce_n_o && !bus1.ram_oe_n_o) ? ram1[bus1.ram_addr_o] : 16'hDEAD;
    assign bus2.ram_data_i = (!bus2.ram_ce_n_o && !bus2.ram_oe_n_o) ? ram2[bus2.ram_addr_o] : 16'hDEAD;

    always @(posedge CLK) begin
        if (!bus1.ram_ce_n_o && !bus1.ram_we_n_o && bus1.ram_data_oe_o)
            ram1[bus1.ram_addr_o] = bus1.ram_data_o;
        if (!bus2.ram_ce_n_o && !bus2.ram_we_n_o && bus2.ram_data_oe_o)
            ram2[bus2.ram_addr_o] = bus2.ram_data_o;
    end

    int vectors    = 0;
    int miscompares = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        ram1[0] = 16'h4801; ram1[1] = 16'h4802; ram1[2] = 16'h4803;
        bus1.mem_rd_i = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        vectors++; if (bus1.ram_ce_n_o !== 1'b1) begin miscompares++; $display("FAIL rst_ce_n: got %b want 1", bus1.ram_ce_n_o); end
        vectors++; if (bus1.ram_oe_n_o !== 1'b1) begin miscompares++; $display("FAIL rst_oe_n: got %b want 1", bus1.ram_oe_n_o); end
        vectors++; if (bus1.ram_we_n_o !== 1'b1) begin miscompares++; $display("FAIL rst_we_n: got %b want 1", bus1.ram_we_n_o); end
        vectors++; if (bus1.ram_data_oe_o !== 1'b0) begin miscompares++; $display("FAIL rst_data_oe: got %b want 0", bus1.ram_data_oe_o); end
        vectors++; if (bus1.stall_pc_o !== 1'b1) begin miscompares++; $display("FAIL rst_stall: got %b want 1", bus1.stall_pc_o); end
        vectors++; if (bus1.instr_o !== 16'h0800) begin miscompares++; $display("FAIL rst_instr: got %h want 0800", bus1.instr_o); end
        vectors++; if (bus1.mem_busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus1.mem_busy_o); end
        vectors++; if (bus1.mem_rdata_o !== 16'h0000) begin miscompares++; $display("FAIL rst_rdata: got %h want 0000", bus1.mem_rdata_o); end
        bus1.mem_rd_i = 1'b0;
        #1 RST = 1'b1;
        #1;
        vectors++; if (bus1.ram_ce_n_o !== 1'b1) begin miscompares++; $display("FAIL rel_idle_ce_n: got %b want 1", bus1.ram_ce_n_o); end
        next_cycle();
        @(negedge CLK);
        vectors++; if (bus1.ram_ce_n_o !== 1'b0) begin miscompares++; $display("FAIL rel_first_ce_n: got %b want 0", bus1.ram_ce_n_o); end
        vectors++; if (bus1.stall_pc_o !== 1'b0) begin miscompares++; $display("FAIL rel_first_stall: got %b want 0", bus1.stall_pc_o); end
        next_cycle();
    endtask

    task automatic test_fetch_stream();
        logic [15:0] vals [3];
        vals = '{16'h4801, 16'h4802, 16'h4803};
        for (int i = 0; i < 3; i++) begin
            bus1.pc_i = 16'(i);
            exp_q.push_back(vals[i]);
            @(negedge CLK);
            vectors++; if (bus1.stall_pc_o !== 1'b0) begin miscompares++; $display("FAIL stream_stall[%0d]: got %b want 0", i, bus1.stall_pc_o); end
            exp_v = exp_q.pop_front();
            vectors++; if (bus1.instr_o !== exp_v) begin miscompares++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus1.instr_o, exp_v); end
            next_cycle();
        end
    endtask

    task automatic test_data_read();
        ram1[16'h0005] = 16'h4805; ram1[16'h8000] = 16'hBEEF;
        bus1.pc_i = 16'h0005; bus1.mem_rd_i = 1'b1; bus1.mem_addr_i = 16'h8000;
        exp_q.push_back(16'hBEEF);
        @(negedge CLK);
        vectors++; if (bus1.mem_busy_o !== 1'b1) begin miscompares++; $display("FAIL rd_busy_req: got %b want 1", bus1.mem_busy_o); end
        vectors++; if (bus1.stall_pc_o !== 1'b1 || bus1.instr_o !== 16'h0800) begin miscompares++; $display("FAIL rd_preempt: got stall=%b instr=%h want 1/0800", bus1.stall_pc_o, bus1.instr_o); end
        next_cycle();
        @(negedge CLK);
        vectors++; if (bus1.mem_busy_o !== 1'b0) begin miscompares++; $display("FAIL rd_busy_done: got %b want 0", bus1.mem_busy_o); end
        vectors++; if (bus1.stall_pc_o !== 1'b1) begin miscompares++; $display("FAIL rd_stall_drd: got %b want 1", bus1.stall_pc_o); end
        vectors++; if (bus1.ram_addr_o !== 16'h8000 || bus1.ram_oe_n_o !== 1'b0 || bus1.ram_data_oe_o !== 1'b0) begin miscompares++; $display("FAIL rd_bus: got addr=%h oe_n=%b doe=%b want 8000/0/0", bus1.ram_addr_o, bus1.ram_oe_n_o, bus1.ram_data_oe_o); end
        next_cycle();
        bus1.mem_rd_i = 1'b0;
        @(negedge CLK);
        exp_v = exp_q.pop_front();
        vectors++; if (bus1.mem_rdata_o !== exp_v) begin miscompares++; $display("FAIL rd_rdata: got %h want %h", bus1.mem_rdata_o, exp_v); end
        vectors++; if (bus1.stall_pc_o !== 1'b0 || bus1.instr_o !== 16'h4805) begin miscompares++; $display("FAIL rd_resume: got stall=%b instr=%h want 0/4805", bus1.stall_pc_o, bus1.instr_o); end
        next_cycle();
    endtask

    task automatic test_data_write();
        ram1[16'h8001] = 16'h0000;
        bus1.mem_wr_i = 1'b1; bus1.mem_addr_i = 16'h8001; bus1.mem_wdata_i = 16'h00A5;
        exp_q.push_back(16'h00A5);
        @(negedge CLK);
        vectors++; if (bus1.mem_busy_o !== 1'b1) begin miscompares++; $display("FAIL wr_busy_req: got %b want 1", bus1.mem_busy_o); end
        next_cycle(); @(negedge CLK);
        vectors++; if (bus1.ram_we_n_o !== 1'b1 || bus1.ram_data_oe_o !== 1'b1 || bus1.ram_oe_n_o !== 1'b1 || bus1.mem_busy_o !== 1'b1) begin miscompares++; $display("FAIL wr_setup: got we_n=%b doe=%b oe_n=%b busy=%b want 1/1/1/1", bus1.ram_we_n_o, bus1.ram_data_oe_o, bus1.ram_oe_n_o, bus1.mem_busy_o); end
        next_cycle(); @(negedge CLK);
        vectors++; if (bus1.ram_we_n_o !== 1'b0 || bus1.mem_busy_o !== 1'b1) begin miscompares++; $display("FAIL wr_pulse: got we_n=%b busy=%b want 0/1", bus1.ram_we_n_o, bus1.mem_busy_o); end
        vectors++; if (bus1.ram_addr_o !== 16'h8001 || bus1.ram_data_o !== 16'h00A5) begin miscompares++; $display("FAIL wr_bus: got addr=%h data=%h want 8001/00a5", bus1.ram_addr_o, bus1.ram_data_o); end
        next_cycle(); @(negedge CLK);
        vectors++; if (bus1.ram_we_n_o !== 1'b1 || bus1.mem_busy_o !== 1'b0 || bus1.ram_data_oe_o !== 1'b1) begin miscompares++; $display("FAIL wr_hold: got we_n=%b busy=%b doe=%b want 1/0/1", bus1.ram_we_n_o, bus1.mem_busy_o, bus1.ram_data_oe_o); end
        next_cycle();
        bus1.mem_wr_i = 1'b0;
        @(negedge CLK);
        exp_v = exp_q.pop_front();
        vectors++; if (ram1[16'h8001] !== exp_v) begin miscompares++; $display("FAIL wr_ram: got %h want %h", ram1[16'h8001], exp_v); end
        vectors++; if (bus1.stall_pc_o !== 1'b0) begin miscompares++; $display("FAIL wr_resume: got %b want 0", bus1.stall_pc_o); end
        next_cycle();
    endtask

    task automatic test_rd_wr_both();
        ram1[16'h8002] = 16'h1111;
        bus1.mem_rd_i = 1'b1; bus1.mem_wr_i = 1'b1;
        bus1.mem_addr_i = 16'h8002; bus1.mem_wdata_i = 16'h5A5A;
        next_cycle(); @(negedge CLK);
        vectors++; if (bus1.ram_data_oe_o !== 1'b1) begin miscompares++; $display("FAIL both_is_write: got doe=%b want 1", bus1.ram_data_oe_o); end
        next_cycle(); next_cycle(); @(negedge CLK);
        vectors++; if (bus1.mem_busy_o !== 1'b0) begin miscompares++; $display("FAIL both_hold_busy: got %b want 0", bus1.mem_busy_o); end
        next_cycle();
        bus1.mem_rd_i = 1'b0; bus1.mem_wr_i = 1'b0;
        @(negedge CLK);
        vectors++; if (ram1[16'h8002] !== 16'h5A5A) begin miscompares++; $display("FAIL both_ram: got %h want 5a5a", ram1[16'h8002]); end
        vectors++; if (bus1.mem_rdata_o !== 16'hBEEF) begin miscompares++; $display("FAIL both_rdata: got %h want beef", bus1.mem_rdata_o); end
        next_cycle();
    endtask

    task automatic sync_wait2(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while (bus2.stall_pc_o !== 1'b0 && n < 6) begin
            @(negedge CLK);
            n++;
        end
        vectors++; if (bus2.stall_pc_o !== 1'b0) begin miscompares++; $display("FAIL %s_sync: got stall=%b want 0 within 6 cycles", tag, bus2.stall_pc_o); end
    endtask

    task automatic test_wait2();
        ram2[16'h0010] = 16'h1234;
        bus2.pc_i = 16'h0010;
        sync_wait2("w2");
        vectors++; if (bus2.instr_o !== 16'h1234) begin miscompares++; $display("FAIL w2_first_instr: got %h want 1234", bus2.instr_o); end
        for (int k = 0; k < 6; k++) begin
            next_cycle(); @(negedge CLK);
            if (k % 2 == 0) exp_v = 16'h0800; else exp_v = 16'h1234;
            vectors++; if (bus2.stall_pc_o !== (k % 2 == 0) || bus2.instr_o !== exp_v) begin miscompares++; $display("FAIL w2_cycle[%0d]: got stall=%b instr=%h want %b/%h", k, bus2.stall_pc_o, bus2.instr_o, (k % 2 == 0), exp_v); end
        end
    endtask

    task automatic test_preempt_wait2();
        ram2[16'h9000] = 16'hC0DE;
        sync_wait2("pw2");
        next_cycle();
        next_cycle();
        bus2.mem_rd_i = 1'b1; bus2.mem_addr_i = 16'h9000;
        exp_q.push_back(16'hC0DE);
        @(negedge CLK);
        vectors++; if (bus2.stall_pc_o !== 1'b0 || bus2.instr_o !== 16'h1234 || bus2.mem_busy_o !== 1'b1) begin miscompares++; $display("FAIL pw2_finish_fetch: got stall=%b instr=%h busy=%b want 0/1234/1", bus2.stall_pc_o, bus2.instr_o, bus2.mem_busy_o); end
        next_cycle(); @(negedge CLK);
        vectors++; if (bus2.stall_pc_o !== 1'b1 || bus2.mem_busy_o !== 1'b1) begin miscompares++; $display("FAIL pw2_preempt: got stall=%b busy=%b want 1/1", bus2.stall_pc_o, bus2.mem_busy_o); end
        next_cycle(); @(negedge CLK);
        vectors++; if (bus2.mem_busy_o !== 1'b1 || bus2.ram_addr_o !== 16'h9000) begin miscompares++; $display("FAIL pw2_drd0: got busy=%b addr=%h want 1/9000", bus2.mem_busy_o, bus2.ram_addr_o); end
        next_cycle(); @(negedge CLK);
        vectors++; if (bus2.mem_busy_o !== 1'b0) begin miscompares++; $display("FAIL pw2_drd1_busy: got %b want 0", bus2.mem_busy_o); end
        next_cycle();
        bus2.mem_rd_i = 1'b0;
        @(negedge CLK);
        exp_v = exp_q.pop_front();
        vectors++; if (bus2.mem_rdata_o !== exp_v || bus2.stall_pc_o !== 1'b1) begin miscompares++; $display("FAIL pw2_rdata: got rdata=%h stall=%b want %h/1", bus2.mem_rdata_o, bus2.stall_pc_o, exp_v); end
        next_cycle(); @(negedge CLK);
        vectors++; if (bus2.stall_pc_o !== 1'b0 || bus2.instr_o !== 16'h1234) begin miscompares++; $display("FAIL pw2_resume: got stall=%b instr=%h want 0/1234", bus2.stall_pc_o, bus2.instr_o); end
    endtask

    task automatic test_drop();
        ram2[16'h9001] = 16'h0000;
        next_cycle();
        next_cycle();
        bus2.mem_wr_i = 1'b1; bus2.mem_addr_i = 16'h9001; bus2.mem_wdata_i = 16'hFFFF;
        @(negedge CLK);
        vectors++; if (bus2.mem_busy_o !== 1'b1 || bus2.stall_pc_o !== 1'b0) begin miscompares++; $display("FAIL drop_req: got busy=%b stall=%b want 1/0", bus2.mem_busy_o, bus2.stall_pc_o); end
        next_cycle();
        bus2.mem_wr_i = 1'b0;
        @(negedge CLK);
        vectors++; if (bus2.mem_busy_o !== 1'b0 || bus2.ram_we_n_o !== 1'b1 || bus2.ram_data_oe_o !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got busy=%b we_n=%b doe=%b want 0/1/0", bus2.mem_busy_o, bus2.ram_we_n_o, bus2.ram_data_oe_o); end
        next_cycle(); @(negedge CLK);
        vectors++; if (bus2.stall_pc_o !== 1'b0 || ram2[16'h9001] !== 16'h0000) begin miscompares++; $display("FAIL drop_fetch: got stall=%b ram=%h want 0/0000", bus2.stall_pc_o, ram2[16'h9001]); end
        next_cycle();
    endtask

    task automatic test_reset_mid_write();
        ram1[16'h0007] = 16'h4807; ram1[16'h8003] = 16'h0000;
        bus1.pc_i = 16'h0007;
        bus1.mem_wr_i = 1'b1; bus1.mem_addr_i = 16'h8003; bus1.mem_wdata_i = 16'h7777;
        next_cycle();
        next_cycle();
        vectors++; if (bus1.ram_we_n_o !== 1'b0) begin miscompares++; $display("FAIL rmw_pulse: got we_n=%b want 0", bus1.ram_we_n_o); end
        #2 RST = 1'b0;
        bus1.mem_wr_i = 1'b0;
        #1;
        vectors++; if (bus1.ram_we_n_o !== 1'b1 || bus1.ram_data_oe_o !== 1'b0) begin miscompares++; $display("FAIL rmw_async: got we_n=%b doe=%b want 1/0", bus1.ram_we_n_o, bus1.ram_data_oe_o); end
        @(negedge CLK);
        #1 RST = 1'b1;
        next_cycle();
        @(negedge CLK);
        vectors++; if (bus1.stall_pc_o !== 1'b0 || bus1.instr_o !== 16'h4807 || bus1.ram_addr_o !== 16'h0007) begin miscompares++; $display("FAIL rmw_fetch: got stall=%b instr=%h addr=%h want 0/4807/0007", bus1.stall_pc_o, bus1.instr_o, bus1.ram_addr_o); end
        vectors++; if (ram1[16'h8003] !== 16'h0000 || bus1.mem_rdata_o !== 16'h0000) begin miscompares++; $display("FAIL rmw_no_write: got ram=%h rdata=%h want 0000/0000", ram1[16'h8003], bus1.mem_rdata_o); end
    endtask

    initial begin
        bus1.pc_i = 16'h0000; bus1.mem_rd_i = 1'b0; bus1.mem_wr_i = 1'b0;
        bus1.mem_addr_i = 16'h0000; bus1.mem_wdata_i = 16'h0000;
        bus2.pc_i = 16'h0000; bus2.mem_rd_i = 1'b0; bus2.mem_wr_i = 1'b0;
        bus2.mem_addr_i = 16'h0000; bus2.mem_wdata_i = 16'h0000;
        test_reset();
        test_fetch_stream();
        test_data_read();
        test_data_write();
        test_rd_wr_both();
        test_wait2();
        test_preempt_wait2();
        test_drop();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
